// File: rtl/ledtest_led_array_if.sv
// Avalon-MM slave bus bundle for the LED output PIO: word address,
// select, active-low write strobe, write data and registered read data.
interface ledtest_led_array_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/ledtest_led_array.sv
// LED output PIO: data register with set/clear aliases, per-bit blink mask
// driven by a programmable prescaler, and one-cycle registered reads.
module ledtest_led_array #(
  parameter int WIDTH        = 8,
  parameter int PERIOD_W     = 26,
  parameter int PERIOD_RESET = 24999999
) (
  input  logic                clk,
  input  logic                reset_n,
  ledtest_led_array_if.slave  bus,
  output logic [WIDTH-1:0]    out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_MASK   = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    mask_q, mask_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [31:0]         readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic             period_wr;
  logic             unused_wd;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign wr_bits   = bus.writedata[WIDTH-1:0];
  assign period_wr = wr_en && (bus.address == ADDR_PERIOD);
  assign unused_wd = ^bus.writedata;

  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:   data_d   = wr_bits;
        ADDR_SET:    data_d   = data_q | wr_bits;
        ADDR_CLEAR:  data_d   = data_q & ~wr_bits;
        ADDR_MASK:   mask_d   = wr_bits;
        ADDR_PERIOD: period_d = bus.writedata[PERIOD_W-1:0];
        default:     ;
      endcase
    end
  end

  // A PERIOD write restarts the blink cycle and wins over a terminal count.
  always_comb begin
    cnt_d   = cnt_q + PERIOD_W'(1);
    phase_d = phase_q;
    if (period_wr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:   readdata_d[WIDTH-1:0]    = data_q;
      ADDR_MASK:   readdata_d[WIDTH-1:0]    = mask_q;
      ADDR_PERIOD: readdata_d[PERIOD_W-1:0] = period_q;
      ADDR_STATUS: readdata_d[0]            = phase_q;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      mask_q     <= '0;
      period_q   <= PERIOD_W'(PERIOD_RESET);
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign out_port     = data_q ^ (mask_q & {WIDTH{phase_q}});

endmodule

// File: tb/tb_ledtest_led_array.sv
// Directed bench for the LED output PIO: register map, set/clear aliases,
// blink timing, PERIOD write priority, ignored writes and async reset.
module tb_ledtest_led_array;
  logic       clk;
  logic       reset_n;
  logic [7:0] out_port;
  int         total;
  int         bad;

  ledtest_led_array_if bus ();

  ledtest_led_array #(
    .WIDTH(8),
    .PERIOD_W(26),
    .PERIOD_RESET(24999999)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(posedge clk);
    #1;
    v = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp;
    total++;
    if (out_port !== 8'h00) begin
      bad++;
      $display("FAIL reset_out_port got=%h want=00", out_port);
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), v);
      exp = (a == 4) ? 32'd24999999 : 32'd0;
      total++;
      if (v !== exp) begin
        bad++;
        $display("FAIL reset_read addr=%0d got=%h want=%h", a, v, exp);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_data_set_clear();
    logic [31:0] v;
    bus_write(3'd0, 32'hFFFF_FFA5);
    total++;
    if (out_port !== 8'hA5) begin
      bad++;
      $display("FAIL data_write got=%h want=a5", out_port);
    end
    bus_write(3'd1, 32'h0000_000F);
    total++;
    if (out_port !== 8'hAF) begin
      bad++;
      $display("FAIL set_write got=%h want=af", out_port);
    end
    bus_write(3'd2, 32'h0000_0081);
    total++;
    if (out_port !== 8'h2E) begin
      bad++;
      $display("FAIL clear_write got=%h want=2e", out_port);
    end
    bus_read(3'd0, v);
    total++;
    if (v !== 32'h0000_002E) begin
      bad++;
      $display("FAIL data_read got=%h want=0000002e", v);
    end
    bus_read(3'd1, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL set_read got=%h want=00000000", v);
    end
    bus_read(3'd2, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL clear_read got=%h want=00000000", v);
    end
    $display("test_data_set_clear done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    bus_write(3'd0, 32'h0000_003C);
    bus_read(3'd0, v);
    total++;
    if (v !== 32'h0000_003C) begin
      bad++;
      $display("FAIL b2b_data got=%h want=0000003c", v);
    end
    bus_write(3'd3, 32'h0000_0055);
    bus_read(3'd3, v);
    total++;
    if (v !== 32'h0000_0055) begin
      bad++;
      $display("FAIL b2b_mask got=%h want=00000055", v);
    end
    bus_write(3'd3, 32'h0);
    $display("test_back_to_back done");
  endtask

  task automatic test_blink();
    logic [7:0] exp_out;
    logic       exp_st;
    bus_write(3'd4, 32'd3);
    bus_write(3'd0, 32'h01);
    bus_write(3'd3, 32'hF0);
    total++;
    if (out_port !== 8'h01) begin
      bad++;
      $display("FAIL blink_start got=%h want=01", out_port);
    end
    bus.address    = 3'd5;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    // k counts rising edges since the PERIOD write edge.
    for (int k = 3; k <= 12; k++) begin
      @(posedge clk);
      #1;
      exp_out = (((k / 4) % 2) == 1) ? 8'hF1 : 8'h01;
      exp_st  = (((k - 1) / 4) % 2) == 1;
      total++;
      if (out_port !== exp_out) begin
        bad++;
        $display("FAIL blink_out k=%0d got=%h want=%h", k, out_port, exp_out);
      end
      total++;
      if (bus.readdata !== {31'd0, exp_st}) begin
        bad++;
        $display("FAIL blink_status k=%0d got=%h want=%h", k, bus.readdata, {31'd0, exp_st});
      end
    end
    bus.chipselect = 1'b0;
    $display("test_blink done");
  endtask

  task automatic test_period_zero();
    logic [7:0] exp_out;
    bus_write(3'd4, 32'd0);
    total++;
    if (out_port !== 8'h01) begin
      bad++;
      $display("FAIL p0_start got=%h want=01", out_port);
    end
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      exp_out = (i % 2 == 1) ? 8'hF1 : 8'h01;
      total++;
      if (out_port !== exp_out) begin
        bad++;
        $display("FAIL p0_toggle i=%0d got=%h want=%h", i, out_port, exp_out);
      end
    end
    // Phase is 0 and cnt == period here, so a terminal toggle would give 1.
    bus_write(3'd4, 32'd5);
    total++;
    if (out_port !== 8'h01) begin
      bad++;
      $display("FAIL p5_priority got=%h want=01", out_port);
    end
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      exp_out = (i == 6) ? 8'hF1 : 8'h01;
      total++;
      if (out_port !== exp_out) begin
        bad++;
        $display("FAIL p5_count i=%0d got=%h want=%h", i, out_port, exp_out);
      end
    end
    $display("test_period_zero done");
  endtask

  task automatic test_ignored_writes();
    logic [31:0] v;
    bus_write(3'd3, 32'h0);
    @(negedge clk);
    bus.address    = 3'd0;
    bus.writedata  = 32'hFF;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.write_n = 1'b1;
    total++;
    if (out_port !== 8'h01) begin
      bad++;
      $display("FAIL nocs_write got=%h want=01", out_port);
    end
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    total++;
    if (out_port !== 8'h01) begin
      bad++;
      $display("FAIL hi_addr_out got=%h want=01", out_port);
    end
    bus_read(3'd0, v);
    total++;
    if (v !== 32'h01) begin
      bad++;
      $display("FAIL hi_addr_data got=%h want=00000001", v);
    end
    bus_read(3'd3, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL hi_addr_mask got=%h want=00000000", v);
    end
    bus_read(3'd4, v);
    total++;
    if (v !== 32'd5) begin
      bad++;
      $display("FAIL hi_addr_period got=%h want=00000005", v);
    end
    bus_read(3'd6, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL read6 got=%h want=00000000", v);
    end
    bus_read(3'd7, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL read7 got=%h want=00000000", v);
    end
    $display("test_ignored_writes done");
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    bus_write(3'd0, 32'hFF);
    bus_write(3'd3, 32'h0F);
    bus_write(3'd4, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    bus.address = 3'd4;
    @(negedge clk);
    #2;
    bus.address    = 3'd0;
    bus.writedata  = 32'h55;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    reset_n        = 1'b0;
    #1;
    total++;
    if (out_port !== 8'h00) begin
      bad++;
      $display("FAIL arst_out got=%h want=00", out_port);
    end
    total++;
    if (bus.readdata !== 32'h0) begin
      bad++;
      $display("FAIL arst_readdata got=%h want=00000000", bus.readdata);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_port !== 8'h00) begin
      bad++;
      $display("FAIL arst_hold got=%h want=00", out_port);
    end
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    reset_n        = 1'b1;
    bus_read(3'd0, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL arst_data got=%h want=00000000", v);
    end
    bus_read(3'd4, v);
    total++;
    if (v !== 32'd24999999) begin
      bad++;
      $display("FAIL arst_period got=%h want=%h", v, 32'd24999999);
    end
    bus_read(3'd3, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL arst_mask got=%h want=00000000", v);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset_n        = 1'b0;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_data_set_clear();
    test_back_to_back();
    test_blink();
    test_period_zero();
    test_ignored_writes();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
